// File: rtl/dbg_pkg.sv
// Shared debug-subsystem types: scheduler FSM encoding and the common debug word width.
package dbg_pkg;
  localparam int DBG_DW = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DONE = 2'd3
  } dbg_state_e;
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after ptr, wrapping modulo NREQ.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic            any,
  output logic [IW-1:0]   idx
);
  always_comb begin
    logic found;
    int   j;
    any   = |valid;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      // explicit wrap keeps non-power-of-2 NREQ from producing out-of-range indices
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && valid[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/dbg_uart_sched.sv
// Round-robin scheduler sharing one debug UART transmitter among NREQ requesters,
// pacing issue on tx_ready and tracking per-requester completions and ACK timeouts.
module dbg_uart_sched
  import dbg_pkg::*;
#(
  parameter  int NREQ   = 4,
  parameter  int DW     = DBG_DW,
  parameter  int ACK_TO = 16,
  parameter  int CW     = 16,
  localparam int IW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW     = $clog2(ACK_TO + 1)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 tx_we,
  output logic [DW-1:0]        tx_data,
  input  logic                 tx_ready,
  output logic [IW-1:0]        grant_id,
  output logic                 busy,
  output logic [NREQ*CW-1:0]   sent_cnt,
  output logic [CW-1:0]        err_cnt
);
  dbg_state_e                state_q, state_d;
  logic [IW-1:0]             rr_q, rr_d, grant_q, grant_d, rr_next;
  logic [DW-1:0]             data_q, data_d;
  logic [NREQ-1:0]           rdy_q, rdy_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [NREQ-1:0][CW-1:0]   sent_q, sent_d;
  logic [CW-1:0]             err_q, err_d;
  logic                      pick_any;
  logic [IW-1:0]             pick_idx;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid (req_valid),
    .ptr   (rr_q),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (tx_ready && pick_any) state_d = ISSUE;
      ISSUE:     state_d = WAIT_ACK;
      WAIT_ACK:  if (!tx_ready) state_d = WAIT_DONE;
                 else if (timer_q == TW'(ACK_TO - 1)) state_d = IDLE;
      WAIT_DONE: if (tx_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  assign rr_next = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + 1'b1;

  // Datapath: grant capture in IDLE, ACK timer, and saturating counters on exit paths.
  always_comb begin
    rr_d    = rr_q;
    grant_d = grant_q;
    data_d  = data_q;
    rdy_d   = '0;
    timer_d = timer_q;
    sent_d  = sent_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (tx_ready && pick_any) begin
        grant_d         = pick_idx;
        data_d          = req_data[pick_idx*DW +: DW];
        rdy_d[pick_idx] = 1'b1;
      end
      ISSUE: timer_d = '0;
      WAIT_ACK: begin
        timer_d = timer_q + 1'b1;
        if (tx_ready && timer_q == TW'(ACK_TO - 1)) begin
          err_d = (err_q == '1) ? err_q : err_q + 1'b1;
          rr_d  = rr_next;
        end
      end
      WAIT_DONE: if (tx_ready) begin
        sent_d[grant_q] = (sent_q[grant_q] == '1) ? sent_q[grant_q] : sent_q[grant_q] + 1'b1;
        rr_d            = rr_next;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_q    <= '0;
      grant_q <= '0;
      data_q  <= '0;
      rdy_q   <= '0;
      timer_q <= '0;
      sent_q  <= '0;
      err_q   <= '0;
    end else begin
      rr_q    <= rr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      timer_q <= timer_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    tx_we     = (state_q == ISSUE);
    busy      = (state_q != IDLE);
    req_ready = rdy_q;
    tx_data   = data_q;
    grant_id  = grant_q;
    sent_cnt  = sent_q;
    err_cnt   = err_q;
  end
endmodule

// File: tb/tb_dbg_uart_sched.sv
// Scoreboard bench for dbg_uart_sched: a transmitter model, requester agents and an
// expected-grant queue checked on every tx_we strobe.
module tb_dbg_uart_sched;
  localparam int NREQ = 4;
  localparam int DW   = 64;
  localparam int CW   = 16;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*DW-1:0]  req_data = '0;
  logic [NREQ-1:0]     req_ready;
  logic                tx_we;
  logic [DW-1:0]       tx_data;
  logic                tx_ready = 1'b1;
  logic [1:0]          grant_id;
  logic                busy;
  logic [NREQ*CW-1:0]  sent_cnt;
  logic [CW-1:0]       err_cnt;

  dbg_uart_sched #(.NREQ(NREQ), .DW(DW), .ACK_TO(16), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_we(tx_we), .tx_data(tx_data), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .sent_cnt(sent_cnt), .err_cnt(err_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct { int id; logic [63:0] data; } exp_t;
  exp_t        exp_q[$];
  int          n_chk = 0, n_fail = 0;
  int          rem[NREQ], seq[NREQ];
  logic [63:0] base_w[NREQ];
  int          we_cnt = 0;
  bit          tx_force = 1'b0;
  int          dly = 0, low = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sent(input int i);
    return sent_cnt[i*CW +: CW];
  endfunction

  // Transmitter model, scoreboard monitor and requester agents, all on the falling edge.
  always @(negedge CLK) begin
    exp_t e;
    if (!tx_force) begin
      if (tx_we) dly = 2;
      else if (dly > 0) begin
        dly--;
        if (dly == 0) begin tx_ready = 1'b0; low = 20; end
      end else if (low > 0) begin
        low--;
        if (low == 0) tx_ready = 1'b1;
      end
    end
    if (tx_we) begin
      we_cnt++;
      if (exp_q.size() == 0) chk("spurious_we", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("grant_id", 64'(grant_id), 64'(e.id));
        chk("tx_data", tx_data, e.data);
        chk("req_ready", 64'(req_ready), 64'(1 << e.id));
      end
    end else if (req_ready != '0) chk("ready_without_we", 64'(req_ready), 0);
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) begin
      rem[i]--;
      seq[i]++;
      if (rem[i] <= 0) req_valid[i] = 1'b0;
      else req_data[i*DW +: DW] = base_w[i] + 64'(seq[i]);
    end
  end

  task automatic load(input int i, input int n, input logic [63:0] b);
    rem[i] = n; seq[i] = 0; base_w[i] = b;
    req_data[i*DW +: DW] = b;
    req_valid[i] = 1'b1;
  endtask

  task automatic expect_w(input int i, input logic [63:0] d);
    exp_t e;
    e.id = i; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int max);
    int  n = 0;
    bit  done = 0;
    while (!done && n < max) begin
      @(negedge CLK);
      n++;
      done = (busy == 1'b0) && (exp_q.size() == 0) && (req_valid == '0);
    end
    chk("idle_reached", 64'(done), 1);
  endtask

  task automatic wait_we(input int max);
    int n = 0;
    bit seen = 0;
    while (!seen && n < max) begin
      @(negedge CLK);
      n++;
      seen = tx_we;
    end
    chk("tx_we_seen", 64'(seen), 1);
  endtask

  initial begin
    int cnt;
    int we0;
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; seq[i] = 0; base_w[i] = '0; end

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_tx_we", 64'(tx_we), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_grant", 64'(grant_id), 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_err", 64'(err_cnt), 0);
    chk("rst_sent", 64'(sent_cnt), 0);
    RST = 1'b0;
    @(negedge CLK);

    // single word from requester 2
    expect_w(2, 64'h0123_4567_89AB_CDEF);
    load(2, 1, 64'h0123_4567_89AB_CDEF);
    wait_idle(200);
    chk("single_we_cnt", 64'(we_cnt), 1);
    chk("single_sent2", 64'(sent(2)), 1);
    chk("single_busy", 64'(busy), 0);

    // wrap and skip: rr=3, only 0 and 1 valid
    expect_w(0, 64'hA000_0000_0000_0000);
    expect_w(1, 64'hA100_0000_0000_0000);
    load(0, 1, 64'hA000_0000_0000_0000);
    load(1, 1, 64'hA100_0000_0000_0000);
    wait_idle(300);
    chk("wrap_sent0", 64'(sent(0)), 1);
    chk("wrap_sent1", 64'(sent(1)), 1);
    chk("wrap_sent3", 64'(sent(3)), 0);

    // ACK timeout with tx_ready stuck high
    tx_force = 1'b1; tx_ready = 1'b1;
    we0 = we_cnt;
    expect_w(0, 64'hB000_0000_0000_0001);
    load(0, 1, 64'hB000_0000_0000_0001);
    wait_we(20);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (!busy) break;
      cnt++;
    end
    chk("ack_to_cycles", 64'(cnt), 16);
    chk("ack_to_we_once", 64'(we_cnt - we0), 1);
    chk("ack_to_err", 64'(err_cnt), 1);
    chk("ack_to_sent0", 64'(sent(0)), 1);
    tx_force = 1'b0;
    @(negedge CLK);

    // rr advanced past 0 by the timeout: 1 is served before 0
    expect_w(1, 64'hC100_0000_0000_0000);
    expect_w(0, 64'hC000_0000_0000_0000);
    load(0, 1, 64'hC000_0000_0000_0000);
    load(1, 1, 64'hC100_0000_0000_0000);
    wait_idle(300);
    chk("rr_adv_sent0", 64'(sent(0)), 2);
    chk("rr_adv_sent1", 64'(sent(1)), 2);

    // transmitter busy in IDLE holds off the grant
    tx_force = 1'b1; tx_ready = 1'b0;
    we0 = we_cnt;
    expect_w(0, 64'hD000_0000_0000_0000);
    load(0, 1, 64'hD000_0000_0000_0000);
    repeat (10) @(negedge CLK);
    chk("hold_no_we", 64'(we_cnt - we0), 0);
    chk("hold_no_accept", 64'(rem[0]), 1);
    tx_ready = 1'b1; tx_force = 1'b0;
    @(negedge CLK);
    chk("hold_release_ready", 64'(req_ready), 64'h1);
    wait_idle(200);
    chk("hold_sent0", 64'(sent(0)), 3);

    // reset while in WAIT_DONE abandons the word
    expect_w(3, 64'hE300_0000_0000_0000);
    load(3, 1, 64'hE300_0000_0000_0000);
    wait_we(20);
    repeat (4) @(negedge CLK);
    chk("mid_wait_done", {62'd0, busy, tx_ready}, 64'h2);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_tx_we", 64'(tx_we), 0);
    chk("mid_rst_grant", 64'(grant_id), 0);
    chk("mid_rst_err", 64'(err_cnt), 0);
    chk("mid_rst_sent", 64'(sent_cnt), 0);
    repeat (25) @(negedge CLK);
    chk("mid_rst_tx_back", 64'(tx_ready), 1);
    chk("mid_rst_not_counted", 64'(sent_cnt), 0);

    // round robin: all four continuously valid, two words each
    for (int n = 0; n < 2; n++)
      for (int i = 0; i < NREQ; i++)
        expect_w(i, {8'hF0 + 8'(i), 56'd0} + 64'(n));
    for (int i = 0; i < NREQ; i++) load(i, 2, {8'hF0 + 8'(i), 56'd0});
    wait_idle(3000);
    for (int i = 0; i < NREQ; i++) chk($sformatf("rr_sent%0d", i), 64'(sent(i)), 2);
    chk("rr_err", 64'(err_cnt), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dbg_uart_sched.md
Name: dbg_uart_sched

Overview:
- Round-robin scheduler that shares the single 64-bit debug UART transmitter between NREQ debug/trace requesters (trace buffer drain, CPU debug port, bus monitor, ...).
- Accepts one 64-bit word per requester over a valid/ready handshake and issues it to the transmitter as a one-cycle write strobe.
- Paces issue on the transmitter's ready flag, so no word is ever strobed while a line is still being shifted out.
- Sits between the debug sources and the UART transmitter in the debug subsystem.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DW, 64, data word width; must match the transmitter data width.
- ACK_TO, 16, max cycles to wait for tx_ready to fall after a strobe before declaring the issue lost.
- CW, 16, width of each per-requester sent counter and the error counter.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous active-high reset.
- req_valid  in  NREQ  requester i has a word pending.
- req_data  in  NREQ*DW  word of requester i at bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot; word of requester i accepted this cycle.
- tx_we  out  1  one-cycle write strobe to the transmitter.
- tx_data  out  DW  word to the transmitter; held stable from strobe until return to IDLE.
- tx_ready  in  1  transmitter idle/ready flag.
- grant_id  out  clog2(NREQ)  index of the requester currently being served.
- busy  out  1  high in any state other than IDLE.
- sent_cnt  out  NREQ*CW  per-requester count of completed words, saturating.
- err_cnt  out  CW  count of ACK timeouts, saturating.

Behaviour:
- Clocking and reset: one clock, CLK; reset RST is synchronous and active-high.
- Reset values: state=IDLE, tx_we=0, tx_data=0, req_ready=0, grant_id=0, busy=0, all sent_cnt=0, err_cnt=0, round-robin pointer rr=0.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If tx_ready=1 and any req_valid, pick the first valid index at or after rr, searching upward with wrap.
  - Registered on the same edge: grant_id<=g, tx_data<=req_data[g], req_ready[g]<=1 for exactly one cycle, next state ISSUE.
  - If tx_ready=0, wait; no grant is made.
- Requester handshake: the word is taken from req_data in the cycle req_valid[g]=1 is sampled. Requesters must hold valid and data until they see req_ready. req_ready pulses once per accepted word.
- ISSUE: tx_we=1 for exactly one cycle; clear the ACK timer; next state WAIT_ACK.
- WAIT_ACK:
  - tx_ready=0 means the transmitter accepted the word: go to WAIT_DONE.
  - Timer counts 1..ACK_TO; at ACK_TO with tx_ready still 1, go to IDLE, err_cnt+1 (saturating), and advance rr as for a completion.
  - The transmitter registers its strobe, so tx_ready drops 2 cycles after tx_we. Any ACK_TO>=3 must pass.
- WAIT_DONE: on tx_ready=1, sent_cnt[grant_id]+1 (saturating at all-ones), rr<=grant_id+1 mod NREQ, go to IDLE.
- Latency: accept to tx_we is 1 cycle. Back-to-back words need at least 1 IDLE cycle between completion and the next accept.
- Fairness: a requester that keeps valid asserted is served at most once per NREQ grants while others are pending.
- Simultaneous events:
  - Changes to req_valid during non-IDLE states are ignored.
  - A requester dropping valid before grant is not served and not counted.
- Wrap-around: rr and the search wrap modulo NREQ; NREQ non-power-of-2 must work, with grant_id never >= NREQ.
- Reset mid-operation: an in-flight word is abandoned and not counted. tx_we is forced 0 on the reset edge. The transmitter's own reset is independent and not driven by this block.
- Arithmetic: counters use CW-bit unsigned saturating add; no wrap.

Decomposition:
- Shared package dbg_pkg holds the FSM state enum (IDLE/ISSUE/WAIT_ACK/WAIT_DONE, 2 bits) and DBG_DW=64. The transmitter and the trace buffer use the same DBG_DW.
- One sub-module, rr_pick: a combinational round-robin priority picker with inputs valid[NREQ] and ptr, outputs any and idx. It is reused by future debug arbiters.
- Counters and FSM stay in dbg_uart_sched.

Test Plan:
- Single word: NREQ=4, req_valid=0100, req_data[2]=64'h0123_4567_89AB_CDEF, tx_ready model drops 2 cycles after tx_we and rises 20 cycles later -> req_ready=0100 one cycle, tx_we one cycle with tx_data=0123_4567_89AB_CDEF, grant_id=2, sent_cnt[2]=1, busy returns 0.
- Round robin: all four valid continuously for 8 words -> grant order 0,1,2,3,0,1,2,3; each sent_cnt=2.
- Wrap and skip: rr=3 after serving 2, req_valid=0011 -> next grant 0, then 1; requester 3 is not granted.
- ACK timeout: tx_ready stuck at 1, ACK_TO=16 -> tx_we once, return to IDLE 16 cycles after WAIT_ACK entry, err_cnt=1, sent_cnt unchanged, rr advanced.
- Transmitter busy: tx_ready=0 in IDLE with req_valid=0001 -> no req_ready and no tx_we until tx_ready=1, then grant within 1 cycle.
- Reset mid-WAIT_DONE: assert RST one cycle -> next cycle state IDLE, tx_we=0, all counters 0, grant_id=0; the pending word is not counted.
